pipelined_seg_adder: RTL
========================

# pipelined_seg_adder

Parametrised, pipelined segmented adder/subtractor, the successor to the team's fixed 16-bit ripple-carry adder. Operands are split into SEG_W-bit segments, and each pipeline stage resolves one segment. The carry crosses one stage register per cycle, so the critical path is one segment regardless of WIDTH. It takes one operation per cycle under a valid/ready handshake and sits between operand registers and a consumer that may back-pressure.

## Interface
- WIDTH, default 16: operand width; must be a multiple of SEG_W and ≥ SEG_W.
- SEG_W, default 4: segment width, i.e. bits resolved per stage.
- NSEG, derived as WIDTH/SEG_W: number of stages, which is also the latency.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: input operation valid.
- in_ready  out  1: block accepts the operation this cycle.
- in_a  in  WIDTH: operand A.
- in_b  in  WIDTH: operand B.
- in_sub  in  1: 0 computes A+B; 1 computes A−B as A+~B+1.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts the result.
- out_sum  out  WIDTH+1: {carry, sum}. For subtraction the MSB is the carry of A+~B+1, where 1 means no borrow.

## Operation
- Stage k (0..NSEG−1) holds:
  - a valid bit;
  - the carry out of segment k−1;
  - sum segments 0..k−1 computed so far;
  - the not-yet-consumed A segments k..NSEG−1;
  - B segments k..NSEG−1, already inverted when sub=1.
- Stage 0 gets its carry-in from in_sub (0 for add, 1 for sub). B is inverted on acceptance.
- Each stage computes one SEG_W-bit segment: {cout, s} = a_seg + b_seg + cin. It passes cout and the accumulated sum forward and drops the consumed operand segments.
- The last stage register drives out_sum = {cout_last, sum} and out_valid.
- Flow control is a global stall: adv = !out_valid || out_ready, and in_ready = adv (combinational).
  - When adv=1, every stage register loads from its predecessor, and stage 0 loads in_valid.
  - When adv=0, all stages hold.
- A bubble (in_valid=0 while adv=1) propagates as a valid bit of 0.
- Arithmetic is modulo 2^(WIDTH+1) on {carry, sum}. No overflow flag; signed overflow is the consumer's concern.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits 0, all carry/sum/operand registers 0. After reset: out_valid=0, out_sum=0, and in_ready=1.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+NSEG−1, so it is first visible NSEG cycles after acceptance.
- Throughput: 1 operation per cycle while out_ready=1.
- out_valid with out_ready=0: out_sum and out_valid are held stable and in_ready=0 in the same cycle. No operation is lost or duplicated.
- Simultaneous output handshake and input acceptance in one cycle are allowed: the pipeline shifts.
- Empty pipeline: in_ready=1 even when out_ready=0, because out_valid=0.
- Reset mid-operation flushes every in-flight operation. No result emerges for them.
- The carry out of the top segment lands only in out_sum[WIDTH]; there is no wrap into bit 0.

## Configuration
- OPERAND_ISOLATION_EN (low-power build):
  - **Defined:** a stage's data registers (carry, sum, operands) load only when adv=1 and the incoming valid bit is 1. Bubbles do not toggle the datapath, and out_sum holds the last valid result while out_valid=0.
  - **Undefined:** data registers load on every adv cycle regardless of valid, so out_sum is don't-care while out_valid=0.
- Valid bits and handshake behaviour are identical in both builds.

## Structure
- Package adder_pkg:
  - default SEG_W constant;
  - a function computing NSEG from WIDTH/SEG_W;
  - an elaboration check that WIDTH % SEG_W == 0.
- Sub-module seg_adder: a SEG_W-bit combinational segment adder with cin/cout, instantiated once per stage in a generate loop.
- Top level holds the stage registers, skew/operand shifting, and handshake logic.

## Test plan
All scenarios use WIDTH=16, SEG_W=4.
- **Carry ripple:** after reset, A=0xFFFF, B=0x0001, add → out_sum=0x10000 with out_valid exactly 4 cycles after acceptance. Before that, out_valid=0, out_sum=0 and in_ready=1.
- **Subtract with borrow:** A=0x0005, B=0x0007, sub → out_sum=0x0FFFE (MSB 0 means borrow). Also A=0x0007, B=0x0005, sub → out_sum=0x10002.
- **Streaming:** 20 back-to-back random add/sub ops with out_ready=1 → 20 results in order, one per cycle, matching a reference model.
- **Back-pressure:** hold out_ready=0 for 3 cycles while a result is valid → out_sum stable, in_ready=0, no input consumed. Release → results resume with no loss or duplication.
- **Reset mid-operation:** assert rst_n=0 with 3 ops in flight → out_valid=0 and out_sum=0 immediately. After release, no stale results appear.
- **Isolation build:** with OPERAND_ISOLATION_EN, result 0x1234 followed by 5 bubbles → out_sum remains 0x01234 throughout.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared configuration for the pipelined segmented adder: default segment width,
// stage-count derivation and a legality check on the WIDTH/SEG_W pairing.
package adder_pkg;

    localparam int SEG_W_DEFAULT = 4;

    function automatic int calc_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    // WIDTH must be a whole, non-zero number of segments.
    function automatic bit cfg_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/seg_adder.sv
// One SEG_W-bit slice of the pipelined adder: {cout, s} = a + b + cin.
// Purely combinational, no flow control of its own.
module seg_adder #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] s_o,
    output logic             cout_o
);

    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_seg_adder.sv
// Pipelined segmented add/sub, NSEG = WIDTH/SEG_W stages of latency, one op/cycle;
// global stall when out_valid && !out_ready. Low-power build: OPERAND_ISOLATION_EN.
module pipelined_seg_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = SEG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    if (!cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
        $error("pipelined_seg_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage k keeps only the operand segments it has not consumed yet, so the
    // operand registers shrink by SEG_W and the sum register grows by SEG_W per stage.
    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int AW = WIDTH - k * SEG_W;

        logic          vld_q, vld_d;
        logic          c_q, c_d;
        logic [AW-1:0] a_q, a_d;
        logic [AW-1:0] b_q, b_d;
        logic          ld;
        logic [SEG_W-1:0] s;
        logic          co;

        seg_adder #(.SEG_W(SEG_W)) u_seg (
            .a_i    (a_q[SEG_W-1:0]),
            .b_i    (b_q[SEG_W-1:0]),
            .cin_i  (c_q),
            .s_o    (s),
            .cout_o (co)
        );

        if (k == 0) begin : g_head
            assign vld_d = in_valid;
            assign c_d   = in_sub;
            assign a_d   = in_a;
            assign b_d   = in_sub ? ~in_b : in_b;
        end else begin : g_body
            logic [k*SEG_W-1:0] sum_q, sum_d;

            assign vld_d = g_stg[k-1].vld_q;
            assign c_d   = g_stg[k-1].co;
            assign a_d   = g_stg[k-1].a_q[AW+SEG_W-1:SEG_W];
            assign b_d   = g_stg[k-1].b_q[AW+SEG_W-1:SEG_W];

            if (k == 1) begin : g_first
                assign sum_d = g_stg[0].s;
            end else begin : g_rest
                assign sum_d = {g_stg[k-1].s, g_stg[k-1].g_body.sum_q};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q <= '0;
                end else if (ld) begin
                    sum_q <= sum_d;
                end
            end
        end

`ifdef OPERAND_ISOLATION_EN
        assign ld = adv && vld_d;
`else
        assign ld = adv;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
            end else begin
                if (adv) begin
                    vld_q <= vld_d;
                end
                if (ld) begin
                    c_q <= c_d;
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    // The top segment is resolved straight off the last stage register, so the
    // result is stable for as long as that register holds.
    if (NSEG == 1) begin : g_out_single
        assign out_sum = {g_stg[0].co, g_stg[0].s};
    end else begin : g_out_multi
        assign out_sum = {g_stg[NSEG-1].co, g_stg[NSEG-1].s, g_stg[NSEG-1].g_body.sum_q};
    end

    assign out_valid = g_stg[NSEG-1].vld_q;

endmodule
